// File: rtl/alu_multibyte_seq.sv
// alu_multibyte_seq: byte-serial add/sub of NBYTES-wide operands over one
// 8-bit look_ahead_adder, LSB first, with start/busy/done handshake.
// in: clk rst_n start op_sub use_cin cin a b
// out: busy done result cout zero ovf

module look_ahead_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s  = p ^ c[7:0];
  assign co = c[8];

endmodule

module alu_multibyte_seq #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic                  use_cin,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  zero,
  output logic                  ovf
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [NBYTES-1:0][7:0] opa;
  logic [NBYTES-1:0][7:0] opb;
  logic [NBYTES-1:0][7:0] acc;
  logic [NBYTES-1:0][7:0] acc_nxt;
  logic [IW-1:0]          idx;
  logic                   carry;

  logic [7:0] sum;
  logic       co;
  logic       last;
  logic       load;
  logic       step;
  logic       fin;

  look_ahead_adder u_add (
    .a  (opa[idx]),
    .b  (opb[idx]),
    .ci (carry),
    .s  (sum),
    .co (co)
  );

  assign last = (idx == IW'(NBYTES - 1));

  always_comb begin
    acc_nxt      = acc;
    acc_nxt[idx] = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_d = DONE;
          fin     = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (load) begin
        opa   <= a;
        opb   <= op_sub ? ~b : b;
        idx   <= '0;
        carry <= use_cin ? cin : op_sub;
      end
      if (step) begin
        acc   <= acc_nxt;
        carry <= co;
        idx   <= idx + 1'b1;
      end
      if (fin) begin
        result <= acc_nxt;
        cout   <= co;
        zero   <= (acc_nxt == '0);
        // opb already holds ~b for subtract
        ovf    <= (opa[NBYTES-1][7] == opb[NBYTES-1][7]) &&
                  (sum[7] != opa[NBYTES-1][7]);
      end
    end
  end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// tb_alu_multibyte_seq: directed checks of the byte-serial add/sub
// sequencer at NBYTES=2 and NBYTES=4.

module tb_alu_multibyte_seq;

  logic clk;
  logic rst_n;

  logic        s2, sub2, uc2, ci2;
  logic [15:0] a2, b2;
  logic        busy2, done2, co2, z2, v2;
  logic [15:0] r2;

  logic        s4, sub4, uc4, ci4;
  logic [31:0] a4, b4;
  logic        busy4, done4, co4, z4, v4;
  logic [31:0] r4;

  int n_chk;
  int n_pass;
  logic [15:0] prev2;

  alu_multibyte_seq #(.NBYTES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .op_sub(sub2),
    .use_cin(uc2), .cin(ci2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(r2),
    .cout(co2), .zero(z2), .ovf(v2)
  );

  alu_multibyte_seq #(.NBYTES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .op_sub(sub4),
    .use_cin(uc4), .cin(ci4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(r4),
    .cout(co4), .zero(z4), .ovf(v4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic op2(input string tag,
                     input logic [15:0] a_, input logic [15:0] b_,
                     input logic sub, input logic uc, input logic ci,
                     input logic [15:0] er, input logic ec,
                     input logic ez, input logic eo);
    @(negedge clk);
    s2 = 1'b1; a2 = a_; b2 = b_;
    sub2 = sub; uc2 = uc; ci2 = ci;
    @(posedge clk); #1;
    s2 = 1'b0;
    chk({tag, ".busy1"}, busy2, 1'b1);
    chk({tag, ".done1"}, done2, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".busy2"}, busy2, 1'b1);
    chk({tag, ".hold"}, r2, prev2);
    @(posedge clk); #1;
    chk({tag, ".busy3"}, busy2, 1'b0);
    chk({tag, ".done3"}, done2, 1'b1);
    chk({tag, ".res"}, r2, er);
    chk({tag, ".cout"}, co2, ec);
    chk({tag, ".zero"}, z2, ez);
    chk({tag, ".ovf"}, v2, eo);
    @(posedge clk); #1;
    chk({tag, ".done4"}, done2, 1'b0);
    chk({tag, ".keep"}, r2, er);
    prev2 = er;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; prev2 = 16'h0;
    rst_n = 1'b0;
    s2 = 0; sub2 = 0; uc2 = 0; ci2 = 0; a2 = '0; b2 = '0;
    s4 = 0; sub4 = 0; uc4 = 0; ci4 = 0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy2", busy2, 1'b0);
    chk("rst.done2", done2, 1'b0);
    chk("rst.res2", r2, 16'h0);
    chk("rst.flags2", {co2, z2, v2}, 3'b000);
    chk("rst.busy4", busy4, 1'b0);
    chk("rst.res4", r4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    op2("add_rip", 16'h12FF, 16'h0001, 0, 0, 0, 16'h1300, 0, 0, 0);
    op2("sub_nb",  16'h1000, 16'h0001, 1, 0, 0, 16'h0FFF, 1, 0, 0);
    op2("sub_br",  16'h0000, 16'h0001, 1, 0, 0, 16'hFFFF, 0, 0, 0);
    op2("sub_ov",  16'h8000, 16'h0001, 1, 0, 0, 16'h7FFF, 1, 0, 1);
    op2("add_ov",  16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 0, 0, 1);
    op2("add_z",   16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 1, 0);
    op2("adc",     16'h00FF, 16'h0000, 0, 1, 1, 16'h0100, 0, 0, 0);
    op2("sbc",     16'h0005, 16'h0003, 1, 1, 0, 16'h0001, 1, 0, 0);

    // start re-raised and operands changed during RUN (NBYTES=4)
    @(negedge clk);
    s4 = 1'b1; a4 = 32'h01020304; b4 = 32'h10203040;
    sub4 = 0; uc4 = 0; ci4 = 0;
    @(posedge clk); #1;
    chk("ign.busy0", busy4, 1'b1);
    a4 = 32'hFFFFFFFF; b4 = 32'h87654321; sub4 = 1;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("ign.run%0d", i), {busy4, done4}, 2'b10);
    end
    s4 = 1'b0;
    @(posedge clk); #1;
    chk("ign.done", {busy4, done4}, 2'b01);
    chk("ign.res", r4, 32'h11223344);
    chk("ign.flags", {co4, z4, v4}, 3'b000);
    @(posedge clk); #1;
    chk("ign.idle", {busy4, done4}, 2'b00);

    // back-to-back: start held through DONE with a new op
    @(negedge clk);
    s2 = 1'b1; a2 = 16'h0001; b2 = 16'h0002;
    sub2 = 0; uc2 = 0; ci2 = 0;
    @(posedge clk); #1;
    a2 = 16'h1234; b2 = 16'h0034; sub2 = 1;
    @(posedge clk); #1;
    chk("b2b.run", {busy2, done2}, 2'b10);
    @(posedge clk); #1;
    chk("b2b.done1", {busy2, done2}, 2'b01);
    chk("b2b.res1", r2, 16'h0003);
    @(posedge clk); #1;
    s2 = 1'b0;
    chk("b2b.rerun", {busy2, done2}, 2'b10);
    chk("b2b.hold", r2, 16'h0003);
    @(posedge clk); #1;
    chk("b2b.run2", {busy2, done2}, 2'b10);
    @(posedge clk); #1;
    chk("b2b.done2", {busy2, done2}, 2'b01);
    chk("b2b.res2", r2, 16'h1200);
    chk("b2b.cout2", co2, 1'b1);
    @(posedge clk); #1;
    chk("b2b.idle", {busy2, done2}, 2'b00);

    // reset during the second RUN cycle
    @(negedge clk);
    s2 = 1'b1; a2 = 16'h1111; b2 = 16'h2222; sub2 = 0;
    @(posedge clk); #1;
    s2 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.out", {busy2, done2, co2, z2, v2}, 5'b0);
    chk("mrst.res", r2, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mrst.quiet%0d", i), {busy2, done2}, 2'b00);
    end
    prev2 = 16'h0;
    op2("post_rst", 16'h00FF, 16'h0001, 0, 0, 0, 16'h0100, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
